// File: rtl/bcu_pkg.sv
// Shared types for the branch condition unit: opcodes, condition codes and the flags record.
package bcu_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_CMP = 2'd1,
    OP_SUB = 2'd2,
    OP_JCC = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    COND_EQ    = 4'd0,
    COND_NE    = 4'd1,
    COND_GT    = 4'd2,
    COND_LT    = 4'd3,
    COND_GE    = 4'd4,
    COND_LE    = 4'd5,
    COND_HI    = 4'd6,
    COND_LO    = 4'd7,
    COND_RZ    = 4'd8,
    COND_RNEG  = 4'd9,
    COND_RONES = 4'd10,
    COND_AL    = 4'd11
  } cond_e;

  // Packed so that the bit order matches the external {Z,N,C,V} flags port.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/bcu_cond_eval.sv
// Combinational condition evaluator; used for freshly computed CMP flags and for the stored flags.
module bcu_cond_eval
  import bcu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int COND_W = 4
) (
  input  logic [COND_W-1:0] cond,
  input  flags_t            flg,
  input  logic [WIDTH-1:0]  rddata,
  output logic              taken
);

  logic w_zero;
  logic w_neg;
  logic w_ones;

  assign w_zero = ~|rddata;
  assign w_neg  = rddata[WIDTH-1];
  assign w_ones = &rddata;

  // Condition table; register-based codes look at rddata, not the flags.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ:    taken = flg.z;
      COND_NE:    taken = ~flg.z;
      COND_GT:    taken = ~flg.z & (flg.n == flg.v);
      COND_LT:    taken = (flg.n != flg.v);
      COND_GE:    taken = (flg.n == flg.v);
      COND_LE:    taken = flg.z | (flg.n != flg.v);
      COND_HI:    taken = flg.c & ~flg.z;
      COND_LO:    taken = ~flg.c;
      COND_RZ:    taken = w_zero;
      COND_RNEG:  taken = w_neg;
      COND_RONES: taken = w_ones;
      COND_AL:    taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Registered compare/jump evaluator with a persistent Z/N/C/V register and a one-deep
// valid/ready output stage between decode and PC update.
module branch_cond_unit
  import bcu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int COND_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic              r_or_i,
  input  logic [COND_W-1:0] cond,
  input  logic [WIDTH-1:0]  rddata,
  input  logic [WIDTH-1:0]  rsdata,
  input  logic [WIDTH-1:0]  imm,
  input  logic [WIDTH-1:0]  aluout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              jump,
  output logic [3:0]        flags
);

  logic             r_out_valid;
  logic             r_jump;
  flags_t           r_flags;

  op_e              w_op;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_diff;
  flags_t           w_cmp_flags;
  flags_t           w_sub_flags;
  flags_t           w_flags_next;
  logic             w_taken_fresh;
  logic             w_taken_stored;
  logic             w_jump_next;
  logic             w_accept;
  logic             w_produce;

  assign w_op      = op_e'(op);
  assign in_ready  = ~r_out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_produce = w_accept & (w_op != OP_NOP);

  // Subtract as rddata + ~B + 1 so the top bit is the no-borrow carry.
  assign w_b    = r_or_i ? imm : rsdata;
  assign w_diff = {1'b0, rddata} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};

  assign w_cmp_flags.z = ~|w_diff[WIDTH-1:0];
  assign w_cmp_flags.n = w_diff[WIDTH-1];
  assign w_cmp_flags.c = w_diff[WIDTH];
  assign w_cmp_flags.v = (rddata[WIDTH-1] != w_b[WIDTH-1]) &
                         (w_diff[WIDTH-1] != rddata[WIDTH-1]);

  assign w_sub_flags.z = ~|aluout;
  assign w_sub_flags.n = aluout[WIDTH-1];
  assign w_sub_flags.c = w_cmp_flags.c;
  assign w_sub_flags.v = w_cmp_flags.v;

  bcu_cond_eval #(
    .WIDTH  (WIDTH),
    .COND_W (COND_W)
  ) u_eval_fresh (
    .cond   (cond),
    .flg    (w_cmp_flags),
    .rddata (rddata),
    .taken  (w_taken_fresh)
  );

  bcu_cond_eval #(
    .WIDTH  (WIDTH),
    .COND_W (COND_W)
  ) u_eval_stored (
    .cond   (cond),
    .flg    (r_flags),
    .rddata (rddata),
    .taken  (w_taken_stored)
  );

  // Per-opcode next jump value and next flags.
  always_comb begin
    w_jump_next  = 1'b0;
    w_flags_next = r_flags;
    case (w_op)
      OP_CMP: begin
        w_jump_next  = w_taken_fresh;
        w_flags_next = w_cmp_flags;
      end
      OP_SUB: begin
        w_jump_next  = w_sub_flags.z;
        w_flags_next = w_sub_flags;
      end
      OP_JCC: begin
        w_jump_next  = w_taken_stored;
        w_flags_next = r_flags;
      end
      default: begin
        w_jump_next  = 1'b0;
        w_flags_next = r_flags;
      end
    endcase
  end

  // Output stage and flags register; a held result blocks acceptance through in_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_jump      <= 1'b0;
      r_flags     <= '0;
    end else begin
      if (w_produce) begin
        r_out_valid <= 1'b1;
        r_jump      <= w_jump_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_flags <= w_flags_next;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign jump      = r_jump;
  assign flags     = r_flags;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed plus randomized bench for branch_cond_unit against an arithmetic reference model.
module tb_branch_cond_unit;

  localparam int W = 16;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic          r_or_i;
  logic [3:0]    cond;
  logic [W-1:0]  rddata;
  logic [W-1:0]  rsdata;
  logic [W-1:0]  imm;
  logic [W-1:0]  aluout;
  logic          out_valid;
  logic          out_ready;
  logic          jump;
  logic [3:0]    flags;

  int checks = 0;
  int errors = 0;

  logic          exp_valid;
  logic          exp_jump;
  logic [3:0]    exp_flags;

  branch_cond_unit #(.WIDTH(W), .COND_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .r_or_i    (r_or_i),
    .cond      (cond),
    .rddata    (rddata),
    .rsdata    (rsdata),
    .imm       (imm),
    .aluout    (aluout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .jump      (jump),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  // Flags of rd - b from integer arithmetic: equality, unsigned order, signed range.
  function automatic logic [3:0] mdl_cmp(input logic [15:0] rd, input logic [15:0] b);
    int sd;
    logic [15:0] d;
    logic z, n, c, v;
    sd = int'($signed(rd)) - int'($signed(b));
    d  = rd - b;
    z  = (rd == b);
    n  = d[15];
    c  = (rd >= b);
    v  = (sd > 32767) || (sd < -32768);
    return {z, n, c, v};
  endfunction

  function automatic logic mdl_cond(input int c, input logic [3:0] f, input logic [15:0] rd);
    logic z, n, cy, v;
    z = f[3]; n = f[2]; cy = f[1]; v = f[0];
    case (c)
      0:  return z;
      1:  return !z;
      2:  return !z && (n == v);
      3:  return n != v;
      4:  return n == v;
      5:  return z || (n != v);
      6:  return cy && !z;
      7:  return !cy;
      8:  return rd == 16'h0000;
      9:  return rd[15];
      10: return rd == 16'hFFFF;
      11: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_cycle(input logic [1:0] o, input logic ri, input logic [3:0] c,
                          input logic [15:0] rd, input logic [15:0] rs,
                          input logic [15:0] im, input logic [15:0] alu,
                          input logic iv, input logic ordy);
    logic        rdy;
    logic [15:0] b;
    logic [3:0]  f;
    op = o; r_or_i = ri; cond = c; rddata = rd; rsdata = rs; imm = im; aluout = alu;
    in_valid = iv; out_ready = ordy;
    #1;
    rdy = !exp_valid || ordy;
    chk("in_ready", {15'd0, in_ready}, {15'd0, rdy});
    b = ri ? im : rs;
    if (iv && rdy && o != 2'd0) begin
      f = mdl_cmp(rd, b);
      if (o == 2'd1) begin
        exp_jump  = mdl_cond(int'(c), f, rd);
        exp_flags = f;
      end else if (o == 2'd2) begin
        exp_jump  = (alu == 16'h0000);
        exp_flags = {alu == 16'h0000, alu[15], f[1], f[0]};
      end else begin
        exp_jump  = mdl_cond(int'(c), exp_flags, rd);
      end
      exp_valid = 1'b1;
    end else if (exp_valid && ordy) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {15'd0, out_valid}, {15'd0, exp_valid});
    if (exp_valid) chk("jump", {15'd0, jump}, {15'd0, exp_jump});
    chk("flags", {12'd0, flags}, {12'd0, exp_flags});
  endtask

  initial begin
    logic        held_jump;
    logic [3:0]  held_flags;
    logic [15:0] corner [5];
    logic [15:0] ra, rb;
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'hFFFF;

    reset_n = 1'b0; in_valid = 1'b0; op = 2'd0; r_or_i = 1'b0; cond = 4'd0;
    rddata = 16'd0; rsdata = 16'd0; imm = 16'd0; aluout = 16'd0; out_ready = 1'b1;
    exp_valid = 1'b0; exp_jump = 1'b0; exp_flags = 4'b0000;
    #12;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_jump", {15'd0, jump}, 16'd0);
    chk("rst_flags", {12'd0, flags}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed less-than
    do_cycle(2'd1, 1'b0, 4'd3, 16'd5, 16'd7, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("lt_jump", {15'd0, jump}, 16'd1);
    chk("lt_flags", {12'd0, flags}, 16'h0004);

    // Signed overflow versus unsigned ordering
    do_cycle(2'd1, 1'b1, 4'd2, 16'h8000, 16'h1234, 16'd1, 16'd0, 1'b1, 1'b1);
    chk("ovf_jump", {15'd0, jump}, 16'd0);
    chk("ovf_flags", {12'd0, flags}, 16'h0003);
    do_cycle(2'd3, 1'b0, 4'd6, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("jcc_hi", {15'd0, jump}, 16'd1);
    do_cycle(2'd3, 1'b0, 4'd3, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("jcc_lt", {15'd0, jump}, 16'd1);

    // Flags persist across a NOP
    do_cycle(2'd1, 1'b0, 4'd11, 16'd3, 16'd3, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("al_jump", {15'd0, jump}, 16'd1);
    do_cycle(2'd0, 1'b0, 4'd0, 16'd9, 16'd1, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("nop_no_valid", {15'd0, out_valid}, 16'd0);
    do_cycle(2'd3, 1'b0, 4'd0, 16'd9, 16'd1, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("persist_eq", {15'd0, jump}, 16'd1);
    do_cycle(2'd3, 1'b0, 4'd1, 16'd9, 16'd1, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("persist_ne", {15'd0, jump}, 16'd0);

    // SUB takes Z/N from aluout and ignores cond
    do_cycle(2'd2, 1'b0, 4'd1, 16'd4, 16'd4, 16'd0, 16'h0000, 1'b1, 1'b1);
    chk("sub_zero_jump", {15'd0, jump}, 16'd1);
    chk("sub_zero_z", {15'd0, flags[3]}, 16'd1);
    do_cycle(2'd2, 1'b0, 4'd11, 16'd0, 16'd1, 16'd0, 16'hFFFF, 1'b1, 1'b1);
    chk("sub_neg_jump", {15'd0, jump}, 16'd0);
    chk("sub_neg_n", {15'd0, flags[2]}, 16'd1);

    // Backpressure: result held, then queued request taken on release
    do_cycle(2'd1, 1'b0, 4'd3, 16'd5, 16'd9, 16'd0, 16'd0, 1'b1, 1'b0);
    held_jump = jump;
    held_flags = flags;
    for (int i = 0; i < 3; i++) begin
      do_cycle(2'd1, 1'b0, 4'd3, 16'd9, 16'd2, 16'd0, 16'd0, 1'b1, 1'b0);
      chk("hold_jump", {15'd0, jump}, {15'd0, held_jump});
      chk("hold_flags", {12'd0, flags}, {12'd0, held_flags});
    end
    do_cycle(2'd1, 1'b0, 4'd3, 16'd9, 16'd2, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("release_valid", {15'd0, out_valid}, 16'd1);
    chk("release_jump", {15'd0, jump}, 16'd0);

    // Asynchronous reset while a result is held
    do_cycle(2'd1, 1'b0, 4'd7, 16'd1, 16'd2, 16'd0, 16'd0, 1'b1, 1'b0);
    do_cycle(2'd1, 1'b0, 4'd7, 16'd1, 16'd2, 16'd0, 16'd0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    exp_valid = 1'b0; exp_jump = 1'b0; exp_flags = 4'b0000;
    chk("async_out_valid", {15'd0, out_valid}, 16'd0);
    chk("async_jump", {15'd0, jump}, 16'd0);
    chk("async_flags", {12'd0, flags}, 16'd0);
    chk("async_in_ready", {15'd0, in_ready}, 16'd1);
    #1;
    reset_n = 1'b1;

    // Register-based and reserved condition codes
    do_cycle(2'd1, 1'b0, 4'd8, 16'h0000, 16'h0005, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("rz_jump", {15'd0, jump}, 16'd1);
    do_cycle(2'd3, 1'b0, 4'd10, 16'hFFFF, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("rones_jump", {15'd0, jump}, 16'd1);
    do_cycle(2'd1, 1'b0, 4'd13, 16'h0000, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b1);
    chk("code13_jump", {15'd0, jump}, 16'd0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      do_cycle(2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 15)),
               ra, rb, ($urandom_range(0, 3) == 0) ? ra : rb,
               ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
               ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
